// File: rtl/sqrt_controller.sv
`timescale 1ns/1ps
// sqrt_controller
//   Control FSM for an iterative 8-bit integer square-root datapath. One
//   request computes a 4-bit root, one bit per iteration, in four iterations.
//   Each iteration runs SHIFT_A -> CMP -> SHIFT_X.
//
//   State and every output are registered together. The outputs are decoded
//   from the next state, so each Moore output is valid in the same cycle as
//   its state.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     request pulse, sampled only in IDLE
//   a_in      radicand, captured when start is accepted
//   Rsl_X     datapath compare result (one root bit per iteration)
//   abort     cancel request (present only with SQRT_CTRL_ABORT_EN)
//   A         registered radicand driven to the datapath
//   Ld_A, Ld_A_pp, Ld_X   datapath load pulses (LOAD state)
//   Shf_A_pp  shift radicand pair into partial remainder (SHIFT_A state)
//   Shf_X     shift root register (SHIFT_X state)
//   busy      high in every state except IDLE
//   done      one-cycle completion pulse
//   root      result, held until the next accepted start
//
// Build option
//   SQRT_CTRL_ABORT_EN : adds the abort input and its cancel logic.
module sqrt_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] a_in,
  input  logic       Rsl_X,
`ifdef SQRT_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic [7:0] A,
  output logic       Ld_A,
  output logic       Ld_A_pp,
  output logic       Ld_X,
  output logic       Shf_A_pp,
  output logic       Shf_X,
  output logic       busy,
  output logic       done,
  output logic [3:0] root
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_A,
    CMP,
    SHIFT_X,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [1:0] it_q, it_d;
  logic [3:0] sreg_q, sreg_d;
  logic [3:0] root_q, root_d;
  logic       ld_q, ld_d;
  logic       shf_a_q, shf_a_d;
  logic       shf_x_q, shf_x_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    it_d    = it_q;
    sreg_d  = sreg_q;
    root_d  = root_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          state_d = LOAD;
        end
      end
      LOAD: begin
        it_d    = 2'd3;
        sreg_d  = '0;
        state_d = SHIFT_A;
      end
      SHIFT_A: state_d = CMP;
      CMP: begin
        // The root is built MSB first; the first compare yields bit 3.
        sreg_d  = {sreg_q[2:0], Rsl_X};
        state_d = SHIFT_X;
      end
      SHIFT_X: begin
        if (it_q == 2'd0) begin
          state_d = DONE;
        end else begin
          it_d    = it_q - 2'd1;
          state_d = SHIFT_A;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef SQRT_CTRL_ABORT_EN
    // Abort wins over start in IDLE and cancels any iteration in progress.
    // DONE is allowed to finish. Iteration state is left untouched so that
    // root cannot change.
    if (abort && (state_q != DONE)) begin
      state_d = IDLE;
      a_d     = a_q;
      it_d    = it_q;
      sreg_d  = sreg_q;
    end
`endif

    // Root is loaded on entry to DONE so that it appears together with the
    // registered done pulse. The final root bit was shifted in at the end of
    // the last CMP state, so sreg_q is already complete here.
    if (state_d == DONE) begin
      root_d = sreg_q;
    end

    ld_d    = (state_d == LOAD);
    shf_a_d = (state_d == SHIFT_A);
    shf_x_d = (state_d == SHIFT_X);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      it_q    <= '0;
      sreg_q  <= '0;
      root_q  <= '0;
      ld_q    <= 1'b0;
      shf_a_q <= 1'b0;
      shf_x_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      it_q    <= it_d;
      sreg_q  <= sreg_d;
      root_q  <= root_d;
      ld_q    <= ld_d;
      shf_a_q <= shf_a_d;
      shf_x_q <= shf_x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A        = a_q;
  assign Ld_A     = ld_q;
  assign Ld_A_pp  = ld_q;
  assign Ld_X     = ld_q;
  assign Shf_A_pp = shf_a_q;
  assign Shf_X    = shf_x_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign root     = root_q;

endmodule

// File: tb/tb_sqrt_controller.sv
`timescale 1ns/1ps
// Testbench for sqrt_controller. It contains a behavioural restoring-sqrt
// datapath that answers Rsl_X. Expected roots come from a plain
// floor(sqrt) model.
module tb_sqrt_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_in = '0;
  logic       Rsl_X;
  logic [7:0] A;
  logic       Ld_A, Ld_A_pp, Ld_X, Shf_A_pp, Shf_X, busy, done;
  logic [3:0] root;
`ifdef SQRT_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  sqrt_controller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a_in     (a_in),
    .Rsl_X    (Rsl_X),
`ifdef SQRT_CTRL_ABORT_EN
    .abort    (abort),
`endif
    .A        (A),
    .Ld_A     (Ld_A),
    .Ld_A_pp  (Ld_A_pp),
    .Ld_X     (Ld_X),
    .Shf_A_pp (Shf_A_pp),
    .Shf_X    (Shf_X),
    .busy     (busy),
    .done     (done),
    .root     (root)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: radicand shifter, partial remainder, partial root.
  logic [7:0] dp_a;
  logic [9:0] dp_rem;
  logic [3:0] dp_x;
  logic [9:0] dp_trial;
  assign dp_trial = {4'b0000, dp_x, 2'b01};
  assign Rsl_X    = (dp_rem >= dp_trial);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_a   <= '0;
      dp_rem <= '0;
      dp_x   <= '0;
    end else begin
      if (Ld_A)    dp_a   <= A;
      if (Ld_A_pp) dp_rem <= '0;
      if (Ld_X)    dp_x   <= '0;
      if (Shf_A_pp) begin
        dp_rem <= {dp_rem[7:0], dp_a[7:6]};
        dp_a   <= {dp_a[5:0], 2'b00};
      end
      if (Shf_X) begin
        dp_x <= {dp_x[2:0], Rsl_X};
        if (Rsl_X) dp_rem <= dp_rem - dp_trial;
      end
    end
  end

  function automatic int ref_sqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one edge. On return the bench is in the LOAD cycle (c=1).
  task automatic launch(input logic [7:0] a);
    a_in  = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (A !== 8'd0) begin errors++; $display("FAIL reset_A: got %0d expected 0", A); end
    checks++; if ({Ld_A, Ld_A_pp, Ld_X, Shf_A_pp, Shf_X} !== 5'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 00000", {Ld_A, Ld_A_pp, Ld_X, Shf_A_pp, Shf_X}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (root !== 4'd0) begin errors++; $display("FAIL reset_root: got %0d expected 0", root); end
    // A start that is already high is accepted at the first edge after release.
    a_in  = 8'd49;
    start = 1'b1;
    #2 reset_n = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({Ld_A, Ld_A_pp, Ld_X} !== 3'b111) begin errors++; $display("FAIL first_start_load: got %b expected 111", {Ld_A, Ld_A_pp, Ld_X}); end
    checks++; if (A !== 8'd49) begin errors++; $display("FAIL first_start_A: got %0d expected 49", A); end
    c = 1;
    while (done !== 1'b1 && c < 30) begin tick(); c++; end
    checks++; if (c != 14) begin errors++; $display("FAIL first_start_latency: got %0d expected 14", c); end
    checks++; if (root !== 4'd7) begin errors++; $display("FAIL first_start_root: got %0d expected 7", root); end
    tick();
  endtask

  task automatic test_latency_144();
    launch(8'd144);
    checks++; if ({Ld_A, Ld_A_pp, Ld_X, busy} !== 4'b1111) begin errors++; $display("FAIL lat_load: got %b expected 1111", {Ld_A, Ld_A_pp, Ld_X, busy}); end
    checks++; if (A !== 8'd144) begin errors++; $display("FAIL lat_A: got %0d expected 144", A); end
    for (int c = 1; c <= 15; c++) begin
      checks++; if (done !== 1'(c == 14)) begin errors++; $display("FAIL lat_done c=%0d: got %b expected %b", c, done, c == 14); end
      checks++; if (busy !== 1'(c <= 14)) begin errors++; $display("FAIL lat_busy c=%0d: got %b expected %b", c, busy, c <= 14); end
      if (c == 13) begin checks++; if (root !== 4'd7) begin errors++; $display("FAIL lat_root_early: got %0d expected 7", root); end end
      if (c >= 14) begin checks++; if (root !== 4'd12) begin errors++; $display("FAIL lat_root c=%0d: got %0d expected 12", c, root); end end
      if (c < 15) tick();
    end
  endtask

  task automatic test_corners();
    logic [7:0] vals [5];
    int c;
    vals[0] = 8'd0; vals[1] = 8'd255; vals[2] = 8'd1; vals[3] = 8'd15; vals[4] = 8'd16;
    foreach (vals[i]) begin
      launch(vals[i]);
      c = 1;
      while (done !== 1'b1 && c < 30) begin tick(); c++; end
      checks++; if (c != 14) begin errors++; $display("FAIL corner_latency a=%0d: got %0d expected 14", vals[i], c); end
      checks++; if (root !== 4'(ref_sqrt(int'(vals[i])))) begin errors++; $display("FAIL corner_root a=%0d: got %0d expected %0d", vals[i], root, ref_sqrt(int'(vals[i]))); end
      tick();
    end
  endtask

  task automatic test_pulse_protocol();
    int n_ld, n_sa, n_sx, n_both;
    logic exp_sa, exp_sx;
    logic [7:0] a;
    for (int r = 0; r < 3; r++) begin
      a = 8'($urandom_range(0, 255));
      n_ld = 0; n_sa = 0; n_sx = 0; n_both = 0;
      launch(a);
      for (int c = 1; c <= 14; c++) begin
        exp_sa = (c >= 2) && (c <= 13) && ((c - 2) % 3 == 0);
        exp_sx = (c >= 4) && (c <= 13) && ((c - 4) % 3 == 0);
        checks++; if ({Ld_A, Ld_A_pp, Ld_X} !== {3{1'(c == 1)}}) begin errors++; $display("FAIL proto_ld c=%0d: got %b expected %b", c, {Ld_A, Ld_A_pp, Ld_X}, {3{1'(c == 1)}}); end
        checks++; if (Shf_A_pp !== exp_sa) begin errors++; $display("FAIL proto_shf_a c=%0d: got %b expected %b", c, Shf_A_pp, exp_sa); end
        checks++; if (Shf_X !== exp_sx) begin errors++; $display("FAIL proto_shf_x c=%0d: got %b expected %b", c, Shf_X, exp_sx); end
        if (Ld_A === 1'b1) n_ld++;
        if (Shf_A_pp === 1'b1) n_sa++;
        if (Shf_X === 1'b1) n_sx++;
        if (Shf_A_pp === 1'b1 && Shf_X === 1'b1) n_both++;
        a_in = 8'($urandom);
        tick();
      end
      checks++; if (n_ld != 1) begin errors++; $display("FAIL proto_ld_count: got %0d expected 1", n_ld); end
      checks++; if (n_sa != 4) begin errors++; $display("FAIL proto_shf_a_count: got %0d expected 4", n_sa); end
      checks++; if (n_sx != 4) begin errors++; $display("FAIL proto_shf_x_count: got %0d expected 4", n_sx); end
      checks++; if (n_both != 0) begin errors++; $display("FAIL proto_overlap: got %0d expected 0", n_both); end
      checks++; if (root !== 4'(ref_sqrt(int'(a)))) begin errors++; $display("FAIL proto_root a=%0d: got %0d expected %0d", a, root, ref_sqrt(int'(a))); end
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    n_done = 0;
    launch(8'd144);
    for (int c = 1; c <= 20; c++) begin
      if (done === 1'b1) n_done++;
      if (c == 14) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_cycle: got %b expected 1", done); end
        checks++; if (root !== 4'd12) begin errors++; $display("FAIL b2b_root_at_done: got %0d expected 12", root); end
      end
      start = (c == 5) || (c == 14);
      a_in  = (c == 5 || c == 14) ? 8'd9 : a_in;
      tick();
    end
    start = 1'b0;
    checks++; if (n_done != 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", n_done); end
    checks++; if (root !== 4'd12) begin errors++; $display("FAIL b2b_root: got %0d expected 12", root); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    checks++; if (A !== 8'd144) begin errors++; $display("FAIL b2b_A: got %0d expected 144", A); end
  endtask

  task automatic test_reset_midop();
    int n_done, n_busy, c;
    launch(8'd144);
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    checks++; if ({A, Ld_A, Ld_A_pp, Ld_X, Shf_A_pp, Shf_X, busy, done, root} !== 17'b0) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 0", {A, Ld_A, Ld_A_pp, Ld_X, Shf_A_pp, Shf_X, busy, done, root});
    end
    n_done = 0; n_busy = 0;
    repeat (3) begin tick(); if (done === 1'b1) n_done++; if (busy !== 1'b0) n_busy++; end
    #2 reset_n = 1'b1;
    repeat (16) begin tick(); if (done === 1'b1) n_done++; if (busy !== 1'b0) n_busy++; end
    checks++; if (n_done != 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", n_done); end
    checks++; if (n_busy != 0) begin errors++; $display("FAIL midreset_idle: got %0d busy cycles expected 0", n_busy); end
    launch(8'd100);
    c = 1;
    while (done !== 1'b1 && c < 30) begin tick(); c++; end
    checks++; if (c != 14) begin errors++; $display("FAIL midreset_latency: got %0d expected 14", c); end
    checks++; if (root !== 4'd10) begin errors++; $display("FAIL midreset_root: got %0d expected 10", root); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] a;
    int c;
    for (int r = 0; r < 40; r++) begin
      a = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      launch(a);
      c = 1;
      while (done !== 1'b1 && c < 30) begin
        a_in  = 8'($urandom);
        start = 1'($urandom);
        tick();
        c++;
      end
      start = 1'b0;
      checks++; if (c != 14) begin errors++; $display("FAIL rand_latency a=%0d: got %0d expected 14", a, c); end
      checks++; if (root !== 4'(ref_sqrt(int'(a)))) begin errors++; $display("FAIL rand_root a=%0d: got %0d expected %0d", a, root, ref_sqrt(int'(a))); end
      checks++; if (A !== a) begin errors++; $display("FAIL rand_A a=%0d: got %0d", a, A); end
      tick();
    end
  endtask

`ifdef SQRT_CTRL_ABORT_EN
  task automatic test_abort();
    int c, n_done;
    launch(8'd144);
    c = 1;
    while (done !== 1'b1 && c < 30) begin tick(); c++; end
    tick();
    launch(8'd9);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b expected 0", busy); end
    checks++; if ({Ld_A, Ld_A_pp, Ld_X, Shf_A_pp, Shf_X, done} !== 6'b0) begin errors++; $display("FAIL abort_pulses: got %b expected 000000", {Ld_A, Ld_A_pp, Ld_X, Shf_A_pp, Shf_X, done}); end
    n_done = 0;
    repeat (20) begin tick(); if (done === 1'b1) n_done++; end
    checks++; if (n_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", n_done); end
    checks++; if (root !== 4'd12) begin errors++; $display("FAIL abort_root: got %0d expected 12", root); end
    a_in = 8'd25; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if ({busy, Ld_A} !== 2'b00) begin errors++; $display("FAIL abort_priority: got %b expected 00", {busy, Ld_A}); end
    launch(8'd25);
    c = 1;
    while (done !== 1'b1 && c < 30) begin tick(); c++; end
    checks++; if (c != 14 || root !== 4'd5) begin errors++; $display("FAIL abort_recover: got c=%0d root=%0d expected c=14 root=5", c, root); end
    tick();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency_144();
    test_corners();
    test_pulse_protocol();
    test_back_to_back();
    test_reset_midop();
    test_random();
`ifdef SQRT_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sqrt_controller.md
SQRT_CONTROLLER -- requirements
Module: sqrt_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; reset_n  input  1  async active-low reset.
REQ-002 The block SHALL provide: start  input  1  request pulse, sampled in IDLE only.
REQ-003 The block SHALL provide: a_in  input  8  radicand, captured on accepted start.
REQ-004 The block SHALL provide: Rsl_X  input  1  datapath compare result, one root bit per iteration.
REQ-005 The block SHALL provide: A  output  8  registered radicand driven to datapath.
REQ-006 The block SHALL provide the datapath control pulses Ld_A, Ld_A_pp, Ld_X, Shf_A_pp, Shf_X  output  1 each.
REQ-007 The block SHALL provide: busy  output  1  high in every state except IDLE.
REQ-008 The block SHALL provide: done  output  1  one-cycle completion pulse.
REQ-009 The block SHALL provide: root  output  4  result, held stable until the next accepted start.

Function
REQ-010 The FSM SHALL have the states IDLE, LOAD, SHIFT_A, CMP, SHIFT_X and DONE, with registered state and Moore outputs.
REQ-011 IDLE SHALL go to LOAD when start=1, capturing a_in into A; otherwise it SHALL stay in IDLE.
REQ-012 LOAD SHALL assert Ld_A, Ld_A_pp and Ld_X together for exactly one cycle, load iteration counter it=3, and go to SHIFT_A.
REQ-013 SHIFT_A SHALL assert Shf_A_pp for one cycle and then go to CMP.
REQ-014 CMP SHALL assert no control pulse, SHALL shift Rsl_X into an internal 4-bit shift register (MSB first), and SHALL then go to SHIFT_X.
REQ-015 SHIFT_X SHALL assert Shf_X for one cycle; if it=0 it SHALL go to DONE, otherwise it SHALL decrement it and go to SHIFT_A.
REQ-016 DONE SHALL assert done for one cycle, copy the shift register to root, and return to IDLE unconditionally.
REQ-017 Except for the LOAD group, at most one control pulse SHALL be high in any cycle.
REQ-018 Latency: if start is sampled at edge k, LOAD SHALL occupy cycle k+1, the four iterations SHALL occupy cycles k+2..k+13, and done and the new root SHALL be valid in cycle k+14.
REQ-019 start SHALL be ignored in every state other than IDLE, including DONE; a_in changes while busy SHALL have no effect.
REQ-020 The iteration counter SHALL be 2 bits wide and SHALL never wrap below 0 (the exit is taken at it=0).
REQ-021 root SHALL equal floor(sqrt(a_in)) for every a_in in 0..255, given a correct datapath.

Reset
REQ-022 reset_n=0 SHALL immediately force: state=IDLE, A=0, all control pulses=0, busy=0, done=0, root=0, shift register=0, it=0.
REQ-023 An assertion of reset_n mid-operation SHALL abandon the computation with no done pulse; after release the FSM SHALL wait in IDLE for a new start.
REQ-024 The first accepted start SHALL be the one sampled at the first rising edge after reset_n deasserts.

Configuration
REQ-025 When SQRT_CTRL_ABORT_EN is defined, the block SHALL have an added input abort (1 bit).
REQ-026 With SQRT_CTRL_ABORT_EN defined, abort=1 in any non-IDLE state except DONE SHALL send the FSM to IDLE at the next edge, suppress done, leave root unchanged, and deassert all control pulses.
REQ-027 With SQRT_CTRL_ABORT_EN defined, abort SHALL have priority over start in IDLE, so no start is accepted that cycle.
REQ-028 When SQRT_CTRL_ABORT_EN is undefined, the abort port and its logic SHALL be absent and behaviour SHALL be exactly as in REQ-010..REQ-021.

Verification
REQ-029 The bench SHALL cover: a_in=144, start at edge k -> done=1 at cycle k+14, root=12, busy cleared at k+15.
REQ-030 The bench SHALL cover: a_in=0 -> root=0; a_in=255 -> root=15; a_in=1 -> root=1; a_in=15 -> root=3; a_in=16 -> root=4.
REQ-031 The bench SHALL cover: a second start with a_in=9 issued at k+5 and again at k+14 (DONE) -> both ignored, root=12, and done pulses exactly once.
REQ-032 The bench SHALL cover: reset_n low at k+7 -> all outputs 0 immediately, no done pulse, then a new start with a_in=100 -> root=10.
REQ-033 The bench SHALL cover a pulse protocol check: Ld_* high only in LOAD, and over a full run Shf_A_pp count=4 and Shf_X count=4, never high in the same cycle.
REQ-034 The bench SHALL cover, with SQRT_CTRL_ABORT_EN defined: abort at k+6 -> IDLE at k+7, no done, root keeps its previous value 12.
